// File: rtl/monitor_pkg.sv
// Shared defaults and event record for the LTL monitor violation path.
package monitor_pkg;
  localparam int MON_NUM_PROPS = 7;
  localparam int MON_SYM_W     = 8;
  localparam int MON_TS_W      = 32;

  function automatic int prop_id_w(input int num_props);
    return (num_props > 1) ? $clog2(num_props) : 1;
  endfunction

  typedef struct packed {
    logic [prop_id_w(MON_NUM_PROPS)-1:0] prop;
    logic [MON_SYM_W-1:0]                symbol;
    logic [MON_TS_W-1:0]                 ts;
  } mon_event_t;
endpackage

// File: rtl/mon_event_fifo.sv
// Shift-register FIFO of violation events; entry 0 is the registered head, valid the cycle after a push.
// A push is taken when not full, or when full and the head is popping that cycle; no empty bypass.
module mon_event_fifo
  import monitor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_vld,
  input  mon_event_t wr_dat,
  input  logic       rd_rdy,
  output mon_event_t rd_dat,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  mon_event_t    ent_q [DEPTH];
  mon_event_t    ent_d [DEPTH];
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_idx;
  logic          pop, push;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign rd_dat = ent_q[0];
  assign pop    = ~empty & rd_rdy;
  assign push   = wr_vld & (~full | pop);

  always_comb begin
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    // Low bits of a full count are zero, so full-with-pop wraps to DEPTH-1.
    wr_idx = cnt_q[AW-1:0] - AW'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      cnt_d = cnt_q - (AW+1)'(1);
    end
    if (push) begin
      ent_d[wr_idx] = wr_dat;
      cnt_d         = cnt_d + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end
endmodule

// File: rtl/monitor_violation_collector.sv
// Collects LTL violation onsets: sticky/count status, pending per property, timestamped event queue.
// Onset to report_valid is 2 cycles minimum; a full queue leaves events pending, a repeat onset sets overflow.
module monitor_violation_collector
  import monitor_pkg::*;
#(
  parameter  int NUM_PROPS = MON_NUM_PROPS,
  parameter  int SYM_W     = MON_SYM_W,
  parameter  int TS_W      = MON_TS_W,
  parameter  int CNT_W     = 8,
  parameter  int DEPTH     = 4,
  localparam int PID_W     = prop_id_w(NUM_PROPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [SYM_W-1:0]         symbols,
  input  logic [NUM_PROPS-1:0]     ltl_flags,
  input  logic                     clear,
  output logic                     report_valid,
  input  logic                     report_ready,
  output logic [PID_W-1:0]         report_prop,
  output logic [SYM_W-1:0]         report_symbol,
  output logic [TS_W-1:0]          report_ts,
  output logic [NUM_PROPS-1:0]     sticky,
  output logic [NUM_PROPS*CNT_W-1:0] counts,
  output logic                     overflow,
  output logic                     irq
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]      ts_q, ts_d;
  logic [NUM_PROPS-1:0] flag_q, flag_d;
  logic [NUM_PROPS-1:0] sticky_q, sticky_d;
  logic [NUM_PROPS-1:0] pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q [NUM_PROPS];
  logic [CNT_W-1:0]     cnt_d [NUM_PROPS];
  logic [SYM_W-1:0]     sym_cap_q [NUM_PROPS];
  logic [SYM_W-1:0]     sym_cap_d [NUM_PROPS];
  logic [TS_W-1:0]      ts_cap_q [NUM_PROPS];
  logic [TS_W-1:0]      ts_cap_d [NUM_PROPS];

  logic [NUM_PROPS-1:0] onset, push_mask;
  logic [PID_W-1:0]     sel_prop;
  logic [SYM_W-1:0]     sel_sym;
  logic [TS_W-1:0]      sel_ts;
  logic                 push_vld, push_acc, pop;
  logic                 fifo_full, fifo_empty;
  mon_event_t           push_dat, head_dat;

  assign onset = ltl_flags & ~flag_q & {NUM_PROPS{run}};
  assign pop   = report_valid & report_ready;

  // Lowest pending id wins the single push slot.
  always_comb begin
    sel_prop = '0;
    sel_sym  = '0;
    sel_ts   = '0;
    for (int i = NUM_PROPS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_prop = PID_W'(i);
        sel_sym  = sym_cap_q[i];
        sel_ts   = ts_cap_q[i];
      end
    end
    push_vld        = |pend_q;
    push_acc        = push_vld & (~fifo_full | pop);
    push_mask       = push_acc ? (NUM_PROPS'(1) << sel_prop) : '0;
    push_dat.prop   = sel_prop;
    push_dat.symbol = sel_sym;
    push_dat.ts     = sel_ts;
  end

  // Clear is applied first so a coincident onset survives it.
  always_comb begin
    ts_d     = run ? ts_q + TS_W'(1) : ts_q;
    flag_d   = run ? ltl_flags : flag_q;
    sticky_d = (clear ? '0 : sticky_q) | (ltl_flags & {NUM_PROPS{run}});
    pend_d   = ((clear ? '0 : pend_q) & ~push_mask) | onset;
    ovf_d    = ~clear & (ovf_q | (|(onset & pend_q & ~push_mask)));
    for (int i = 0; i < NUM_PROPS; i++) begin
      cnt_d[i] = clear ? '0 : cnt_q[i];
      if (onset[i] && cnt_d[i] != CNT_MAX) cnt_d[i] = cnt_d[i] + CNT_W'(1);
      sym_cap_d[i] = onset[i] ? symbols : sym_cap_q[i];
      ts_cap_d[i]  = onset[i] ? ts_q    : ts_cap_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q     <= '0;
      flag_q   <= '0;
      sticky_q <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NUM_PROPS; i++) begin
        cnt_q[i]     <= '0;
        sym_cap_q[i] <= '0;
        ts_cap_q[i]  <= '0;
      end
    end else begin
      ts_q      <= ts_d;
      flag_q    <= flag_d;
      sticky_q  <= sticky_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      sym_cap_q <= sym_cap_d;
      ts_cap_q  <= ts_cap_d;
    end
  end

  mon_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .rd_rdy (report_ready),
    .rd_dat (head_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign report_valid  = ~fifo_empty;
  assign irq           = report_valid;
  assign report_prop   = head_dat.prop;
  assign report_symbol = head_dat.symbol;
  assign report_ts     = head_dat.ts;
  assign sticky        = sticky_q;
  assign overflow      = ovf_q;

  always_comb begin
    counts = '0;
    for (int i = 0; i < NUM_PROPS; i++) counts[i*CNT_W +: CNT_W] = cnt_q[i];
  end
endmodule

// File: tb/tb_monitor_violation_collector.sv
// Scoreboard bench for monitor_violation_collector: expected events queued at onset, checked at handshake.
`timescale 1ns/1ps
module tb_monitor_violation_collector;
  logic        clk = 1'b0;
  logic        reset, run, clear, report_ready;
  logic [7:0]  symbols;
  logic [6:0]  ltl_flags;
  logic        report_valid, overflow, irq;
  logic [2:0]  report_prop;
  logic [7:0]  report_symbol;
  logic [31:0] report_ts;
  logic [6:0]  sticky;
  logic [55:0] counts;

  typedef struct {
    logic [2:0]  prop;
    logic [7:0]  sym;
    logic [31:0] ts;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ts_m;
  logic [31:0] ts_frozen;

  monitor_violation_collector dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .symbols       (symbols),
    .ltl_flags     (ltl_flags),
    .clear         (clear),
    .report_valid  (report_valid),
    .report_ready  (report_ready),
    .report_prop   (report_prop),
    .report_symbol (report_symbol),
    .report_ts     (report_ts),
    .sticky        (sticky),
    .counts        (counts),
    .overflow      (overflow),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Run-cycle counter: the timestamp an onset driven this cycle should carry.
  always @(posedge clk or posedge reset) begin
    if (reset) ts_m <= '0;
    else if (run) ts_m <= ts_m + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] p, input logic [7:0] s, input logic [31:0] t);
    exp_q.push_back('{prop: p, sym: s, ts: t});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && report_valid && report_ready) begin
      chk("rpt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rpt_prop", report_prop, mon_e.prop);
        chk("rpt_symbol", report_symbol, mon_e.sym);
        chk("rpt_ts", report_ts, mon_e.ts);
      end
    end
  end

  initial begin
    reset = 1'b0; run = 1'b0; clear = 1'b0; report_ready = 1'b0;
    symbols = '0; ltl_flags = '0;
    #2 reset = 1'b1;
    step(2);
    chk("rst_valid", report_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_counts", counts, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;

    // Single onset at ts=5
    run = 1'b1; symbols = 8'hA5;
    for (int k = 0; k < 20 && ts_m != 5; k++) step(1);
    ltl_flags = 7'b0000100;
    expect_ev(3'd2, 8'hA5, 32'd5);
    step(1);
    chk("t1_lat1_valid", report_valid, 0);
    step(1);
    chk("t1_valid", report_valid, 1);
    chk("t1_prop", report_prop, 2);
    chk("t1_symbol", report_symbol, 8'hA5);
    chk("t1_ts", report_ts, 5);
    chk("t1_sticky", sticky, 7'b0000100);
    chk("t1_count2", counts[2*8 +: 8], 1);
    chk("t1_irq", irq, 1);
    report_ready = 1'b1;
    step(1);
    report_ready = 1'b0;
    chk("t1_popped", report_valid, 0);
    ltl_flags = '0;
    step(1);

    // Simultaneous onsets drain in ascending id order
    report_ready = 1'b1; symbols = 8'h3C; ltl_flags = 7'b1010001;
    expect_ev(3'd0, 8'h3C, ts_m);
    expect_ev(3'd4, 8'h3C, ts_m);
    expect_ev(3'd6, 8'h3C, ts_m);
    step(2);
    chk("t2_head0", report_prop, 0);
    step(1);
    chk("t2_head1", report_prop, 4);
    step(1);
    chk("t2_head2", report_prop, 6);
    step(3);
    chk("t2_ovf", overflow, 0);
    chk("t2_drained", report_valid, 0);
    report_ready = 1'b0; ltl_flags = '0;
    step(1);

    // Backpressure: 4 queued, 1 pending, 5th onset overwritten by 6th
    for (int k = 1; k <= 6; k++) begin
      symbols = 8'(k);
      ltl_flags = 7'b0000010;
      if (k != 5) expect_ev(3'd1, 8'(k), ts_m);
      step(1);
      ltl_flags = '0;
      step(1);
    end
    chk("t3_ovf", overflow, 1);
    chk("t3_valid", report_valid, 1);
    chk("t3_count1", counts[1*8 +: 8], 6);
    chk("t3_sticky", sticky, 7'b1010111);
    report_ready = 1'b1;
    step(8);
    chk("t3_drained", report_valid, 0);
    report_ready = 1'b0;

    // Run gating: flag ignored and ts frozen while run=0
    ts_frozen = ts_m;
    run = 1'b0; symbols = 8'h77; ltl_flags = 7'b0001000;
    step(3);
    chk("t4_no_sticky", sticky[3], 0);
    chk("t4_no_valid", report_valid, 0);
    chk("t4_no_count", counts[3*8 +: 8], 0);
    run = 1'b1;
    expect_ev(3'd3, 8'h77, ts_frozen);
    report_ready = 1'b1;
    step(4);
    chk("t4_count3", counts[3*8 +: 8], 1);
    chk("t4_sticky3", sticky[3], 1);
    report_ready = 1'b0; ltl_flags = '0;
    step(1);

    // Clear, then saturate prop 0
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t5_clr_sticky", sticky, 0);
    chk("t5_clr_counts", counts, 0);
    chk("t5_clr_ovf", overflow, 0);
    report_ready = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      symbols = 8'(k);
      ltl_flags = 7'b0000001;
      expect_ev(3'd0, 8'(k), ts_m);
      step(1);
      ltl_flags = '0;
      step(1);
      if (k == 255) chk("t5_cnt255", counts[7:0], 255);
    end
    chk("t5_sat", counts[7:0], 255);
    step(3);
    ltl_flags = 7'b0000001; clear = 1'b1; symbols = 8'hEE;
    expect_ev(3'd0, 8'hEE, ts_m);
    step(1);
    clear = 1'b0;
    chk("t5_col_count", counts[7:0], 1);
    chk("t5_col_sticky", sticky, 7'b0000001);
    chk("t5_col_ovf", overflow, 0);
    step(3);
    chk("t5_drained", report_valid, 0);
    ltl_flags = '0; report_ready = 1'b0;
    step(1);

    // Async reset with 3 events queued
    ltl_flags = 7'b0000111;
    step(5);
    chk("t6_queued", report_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_valid", report_valid, 0);
    chk("t6_rst_irq", irq, 0);
    chk("t6_rst_sticky", sticky, 0);
    chk("t6_rst_counts", counts, 0);
    chk("t6_rst_ovf", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0; ltl_flags = '0;
    step(1);
    run = 1'b1; ltl_flags = 7'b0000001; symbols = 8'h5A;
    expect_ev(3'd0, 8'h5A, 32'd0);
    report_ready = 1'b1;
    step(4);
    chk("t6_drained", report_valid, 0);
    report_ready = 1'b0; ltl_flags = '0;
    step(1);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
